// File: rtl/pipelined_add_chain.sv
// pipelined_add_chain: STAGES-deep register chain adding INCR per stage.
// Valid/ready with bubble collapsing, synchronous flush, occupancy count.
module pipelined_add_chain #(
  parameter int              WIDTH    = 16,
  parameter int              STAGES   = 4,
  parameter logic [WIDTH-1:0] INCR    = WIDTH'(1),
  parameter int              SATURATE = 0,
  localparam int             OCC_W    = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [STAGES-1:0] adv;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              acc, del;

  // One stage of arithmetic: WIDTH+1 bit sum, clamp on carry if saturating.
  function automatic logic [WIDTH-1:0] add_incr(
    input logic [WIDTH-1:0] a
  );
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, INCR};
    if (SATURATE != 0 && s[WIDTH]) begin
      return '1;
    end
    return s[WIDTH-1:0];
  endfunction

  // Advance chain: a stage moves if it is empty or everything below moves.
  // Walked from the tail with a running flag to avoid a self-dependent vector.
  always_comb begin
    logic run;
    adv = '0;
    run = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      run    = run | ~v_q[i];
      adv[i] = run;
    end
  end

  assign in_ready  = adv[0] & ~flush & ~rst;
  assign acc       = in_valid & in_ready;
  assign out_valid = v_q[STAGES-1];
  assign del       = out_valid & out_ready;
  assign out_data  = v_q[STAGES-1] ? d_q[STAGES-1] : '0;
  assign occupancy = occ_q;

  // Next state of the chain: advancing stages take upstream, others hold.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      d_d[i] = d_q[i];
    end
    if (adv[0]) begin
      v_d[0] = acc;
      if (acc) begin
        d_d[0] = add_incr(in_data);
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = add_incr(d_q[i-1]);
        end
      end
    end
    if (flush) begin
      v_d = '0;
    end
  end

  // Occupancy tracks accepted minus delivered; flush empties the chain.
  always_comb begin
    occ_d = occ_q + OCC_W'(acc) - OCC_W'(del);
    if (flush) begin
      occ_d = '0;
    end
  end

  // Stage valid/data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Occupancy must always equal the number of valid stages.
  a_occ_matches: assert property (
    @(posedge clk) disable iff (rst)
    int'(occ_q) == $countones(v_q)
  );

endmodule

// File: tb/tb_pipelined_add_chain.sv
// tb_pipelined_add_chain: scoreboard bench over wrap and saturate builds.
// Three instances share stimulus; a negedge monitor checks every output.
module tb_pipelined_add_chain;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         flush;
  logic         ir0, ir1, ir2;
  logic         ov0, ov1, ov2;
  logic [W-1:0] od0, od1, od2;
  logic [2:0]   oc0, oc1, oc2;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_add_chain #(
    .WIDTH(W), .STAGES(S), .INCR(16'd1), .SATURATE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0),
    .out_ready(out_ready), .flush(flush), .occupancy(oc0)
  );

  pipelined_add_chain #(
    .WIDTH(W), .STAGES(S), .INCR(16'd1), .SATURATE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1),
    .out_ready(out_ready), .flush(flush), .occupancy(oc1)
  );

  pipelined_add_chain #(
    .WIDTH(W), .STAGES(S), .INCR(16'h4000), .SATURATE(1)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2),
    .out_ready(out_ready), .flush(flush), .occupancy(oc2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference: total offset S*incr applied once; saturation is monotonic,
  // so clamping the total equals clamping every stage.
  function automatic logic [W-1:0] ref_out(input int unsigned x,
                                           input int unsigned incr,
                                           input bit sat);
    longint t;
    t = longint'(x) + longint'(S) * longint'(incr);
    if (sat) return (t > 65535) ? 16'hFFFF : W'(t);
    return W'(t % 65536);
  endfunction

  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [W-1:0] pd = '0;

  // Monitor: pop on handshake, mask/hold checks, push on acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) q.delete();
    chk("occupancy", 32'(oc0), q.size());
    chk("occ_agree", {oc1, oc2}, {oc0, oc0});
    chk("valid_agree", {ov1, ov2}, {ov0, ov0});
    chk("ready_agree", {ir1, ir2}, {ir0, ir0});
    if (!ov0) begin
      chk("mask0", 32'(od0), 0);
      chk("mask1", 32'(od1), 0);
      chk("mask2", 32'(od2), 0);
    end
    if (pv && !pr && ov0) chk("hold", 32'(od0), 32'(pd));
    if (ov0) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got %0h expected none", od0);
      end else if (out_ready) begin
        e = q.pop_front();
        chk("out0", 32'(od0), 32'(e.e0));
        chk("out1", 32'(od1), 32'(e.e1));
        chk("out2", 32'(od2), 32'(e.e2));
      end else begin
        chk("peek0", 32'(od0), 32'(q[0].e0));
      end
    end
    if (flush) begin
      chk("flush_in_ready", 32'(ir0), 0);
      q.delete();
    end else if (in_valid && ir0) begin
      e.e0 = ref_out(in_data, 1, 1'b0);
      e.e1 = ref_out(in_data, 1, 1'b1);
      e.e2 = ref_out(in_data, 32'h4000, 1'b1);
      q.push_back(e);
    end
    pv = ov0;
    pr = out_ready;
    pd = od0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (ir0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL push_timeout: got in_ready 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_lat(input logic [W-1:0] x);
    push(x);
    for (int j = 0; j <= S + 1; j++) begin
      chk("latency_valid", 32'(ov0), 32'(j == S - 1));
      tick();
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (q.size() == 0 && !ov0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_occ", 32'(oc0), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx;
    bit a;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    #1;
    chk("rst_valid", 32'(ov0), 0);
    chk("rst_data", 32'(od0), 0);
    chk("rst_occ", 32'(oc0), 0);
    chk("rst_in_ready", 32'(ir0), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(ir0), 1);
    tick();

    push_lat(16'd10);

    push(16'd10);
    push(16'd15);
    push(16'd18);
    for (int j = 0; j <= 4; j++) begin
      chk("b2b_valid", 32'(ov0), 32'(j >= S - 3 && j <= S - 1));
      tick();
    end
    drain();

    push(16'hFFFE);
    push(16'h0001);
    drain();

    out_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = W'(idx);
      #1;
      a = ir0;
      tick();
      if (a) idx++;
    end
    #1;
    chk("bp_accepts", idx - 1, S);
    chk("bp_in_ready", 32'(ir0), 0);
    chk("bp_occ", 32'(oc0), S);
    chk("bp_valid", 32'(ov0), 1);
    chk("bp_hold_data", 32'(od0), 5);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx <= 8; c++) begin
      in_valid = 1'b1;
      in_data  = W'(idx);
      #1;
      a = ir0;
      tick();
      if (a) idx++;
    end
    in_valid = 1'b0;
    drain();

    push(16'd30);
    push(16'd31);
    push(16'd32);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd99;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_valid", 32'(ov0), 0);
    chk("flush_occ", 32'(oc0), 0);
    for (int j = 0; j < S + 2; j++) tick();
    push_lat(16'd20);
    drain();

    push(16'd40);
    push(16'd41);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ov0), 0);
    chk("mid_rst_data", 32'(od0), 0);
    chk("mid_rst_occ", 32'(oc0), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    push_lat(16'd7);
    drain();

    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = ($urandom_range(0, 3) == 0)
                ? W'(16'hFFFF - $urandom_range(0, 15))
                : W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
